// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one external combinational ALU between two requesters
//   clk, rst_n (sync, active-low)
//   req_valid0/1, req_ready0/1, req_a0/1, req_b0/1, req_sel0/1 : requester handshake and operands
//   rsp_valid0/1, rsp_data   : one-cycle result pulse to the issuing requester; rsp_data holds otherwise
//   alu_a, alu_b, alu_sel    : registered ALU drive; alu_result : ALU output
//   busy                     : high while an operation is in flight
//   Optional (ALU_RR_SCHEDULER_STATS_EN): op_cnt0/op_cnt1 count delivered responses per requester
module alu_rr_scheduler #(
    parameter int WIDTH   = 16,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid0,
    input  logic             req_valid1,
    output logic             req_ready0,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [SEL_W-1:0] req_sel0,
    input  logic [SEL_W-1:0] req_sel1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_RR_SCHEDULER_STATS_EN
    output logic [15:0]      op_cnt0,
    output logic [15:0]      op_cnt1,
`endif
    output logic             busy
);
    localparam int CW = $clog2(ALU_LAT) + 1;
    localparam logic IDLE = 1'b0;
    localparam logic EXEC = 1'b1;

    logic          state, last_grant, owner, grant, hs;
    logic [CW-1:0] cnt;

    // On contention the requester that did not win last time gets the ALU
    assign grant      = (req_valid0 && req_valid1) ? ~last_grant : req_valid1;
    assign req_ready0 = (state == IDLE) && req_valid0 && !grant;
    assign req_ready1 = (state == IDLE) && req_valid1 && grant;
    assign hs         = req_ready0 || req_ready1;
    assign busy       = (state == EXEC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_data   <= '0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
`ifdef ALU_RR_SCHEDULER_STATS_EN
            op_cnt0    <= '0;
            op_cnt1    <= '0;
`endif
        end else begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            if (state == IDLE) begin
                if (hs) begin
                    alu_a      <= grant ? req_a1 : req_a0;
                    alu_b      <= grant ? req_b1 : req_b0;
                    alu_sel    <= grant ? req_sel1 : req_sel0;
                    owner      <= grant;
                    last_grant <= grant;
                    state      <= EXEC;
                    cnt        <= '0;
                end
            end else begin
                cnt <= cnt + CW'(1);
                // Operands have been stable for ALU_LAT cycles: capture and return the result
                if (cnt == CW'(ALU_LAT - 1)) begin
                    rsp_data   <= alu_result;
                    rsp_valid0 <= !owner;
                    rsp_valid1 <= owner;
                    state      <= IDLE;
`ifdef ALU_RR_SCHEDULER_STATS_EN
                    op_cnt0    <= op_cnt0 + {15'd0, !owner};
                    op_cnt1    <= op_cnt1 + {15'd0, owner};
`endif
                end
            end
        end
    end
endmodule
